// File: rtl/rx_mux_arb.sv
// rx_mux_arb: multi-channel receive front end.
// Each of NCH channels has a valid/ready byte port and a one-entry buffer.
// A round-robin arbiter merges the buffers into one registered memory port.
// Per-channel idle timers combine into a registered aggregate idle flag.
// Optional feature macro: RX_PWR_GATE_EN adds the pwr_up input. While pwr_up
// is low, ingress is blocked and timers do not reload, but the output stage
// keeps draining.
module rx_mux_arb #(
  parameter int NCH = 4,
  parameter int DW  = 8,
  parameter int TW  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef RX_PWR_GATE_EN
  input  logic                  pwr_up,
`endif
  input  logic [NCH-1:0]        rx_vld,
  input  logic [NCH*DW-1:0]     rx_data,
  output logic [NCH-1:0]        rx_rdy,
  output logic                  mem_vld,
  output logic [$clog2(NCH)-1:0] mem_ch,
  output logic [DW-1:0]         mem_data,
  input  logic                  mem_rdy,
  input  logic                  reg_wr,
  input  logic [$clog2(NCH)-1:0] reg_addr,
  input  logic [TW:0]           reg_data,
  output logic                  idle
);

  localparam int CW = $clog2(NCH);

  // Per-channel configuration and state
  logic [NCH-1:0] r_en;
  logic [TW-1:0]  r_idle_time [NCH];
  logic [TW-1:0]  r_timer     [NCH];
  logic [NCH-1:0] r_buf_vld;
  logic [DW-1:0]  r_buf_data  [NCH];

  // Output stage
  logic          r_mem_vld;
  logic [CW-1:0] r_mem_ch;
  logic [DW-1:0] r_mem_data;
  logic [CW-1:0] r_rr_ptr;
  logic          r_idle;

  // Combinational control
  logic           w_pwr;
  logic           w_any;
  logic [CW-1:0]  w_gidx;
  logic           w_load;
  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_rdy;
  logic [NCH-1:0] w_acc;
  logic [NCH-1:0] w_quiet;

`ifdef RX_PWR_GATE_EN
  assign w_pwr = pwr_up;
`else
  assign w_pwr = 1'b1;
`endif

  // Round-robin search starting one past the last granted channel
  always_comb begin
    int unsigned idx;
    idx    = 0;
    w_any  = 1'b0;
    w_gidx = '0;
    for (int unsigned k = 1; k <= 32'(NCH); k++) begin
      idx = (32'(r_rr_ptr) + k) % 32'(NCH);
      if (!w_any && r_buf_vld[CW'(idx)]) begin
        w_any  = 1'b1;
        w_gidx = CW'(idx);
      end
    end
  end

  assign w_load = (~r_mem_vld | mem_rdy) & w_any;

  // Pop, ready, accept and quiescence per channel
  always_comb begin
    w_pop   = '0;
    w_rdy   = '0;
    w_acc   = '0;
    w_quiet = '0;
    for (int unsigned i = 0; i < 32'(NCH); i++) begin
      w_pop[i]   = w_load & (w_gidx == CW'(i));
      w_rdy[i]   = r_en[i] & w_pwr & (~r_buf_vld[i] | w_pop[i]);
      w_acc[i]   = rx_vld[i] & w_rdy[i];
      w_quiet[i] = (r_timer[i] == '0) & ~rx_vld[i] & ~r_buf_vld[i];
    end
  end

  assign rx_rdy = w_rdy;

  // Config writes, holding buffers and idle timers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en      <= '0;
      r_buf_vld <= '0;
      for (int unsigned i = 0; i < 32'(NCH); i++) begin
        r_idle_time[i] <= TW'(1);
        r_timer[i]     <= TW'(1);
        r_buf_data[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 32'(NCH); i++) begin
        // Addresses >= NCH match no channel, so such writes fall away
        if (reg_wr && (reg_addr == CW'(i))) begin
          r_en[i]        <= reg_data[0];
          r_idle_time[i] <= reg_data[TW:1];
        end
        // Accept wins over pop so a same-cycle pop/accept keeps the entry full
        if (w_acc[i]) begin
          r_buf_vld[i]  <= 1'b1;
          r_buf_data[i] <= rx_data[i*DW +: DW];
        end else if (w_pop[i]) begin
          r_buf_vld[i] <= 1'b0;
        end
        if (rx_vld[i] && r_en[i] && w_pwr)
          r_timer[i] <= r_idle_time[i];
        else if (r_timer[i] != '0)
          r_timer[i] <= r_timer[i] - TW'(1);
      end
    end
  end

  // Registered memory port and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_vld  <= 1'b0;
      r_mem_ch   <= '0;
      r_mem_data <= '0;
      r_rr_ptr   <= CW'(NCH - 1);
    end else if (w_load) begin
      r_mem_vld  <= 1'b1;
      r_mem_ch   <= w_gidx;
      r_mem_data <= r_buf_data[w_gidx];
      r_rr_ptr   <= w_gidx;
    end else if (r_mem_vld && mem_rdy) begin
      r_mem_vld <= 1'b0;
    end
  end

  // Aggregate idle from pre-edge channel and output-stage state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_idle <= 1'b0;
    else       r_idle <= (&w_quiet) & ~r_mem_vld;
  end

  assign mem_vld  = r_mem_vld;
  assign mem_ch   = r_mem_ch;
  assign mem_data = r_mem_data;
  assign idle     = r_idle;

endmodule
